clk_div_gen: RTL and testbench

Parametrised multi-channel clock-enable generator that replaces the single free-running divide counter feeding the CPU core. Each of `NUM_CH` channels divides `Clk` by a runtime-programmable ratio and produces both a one-cycle tick (clock enable) and a 50% square wave. Each channel can also be paused and single-stepped for debug. Everything downstream stays in the `Clk` domain and uses `Tick_Out` as an enable; no derived clocks.

---
 rtl/clk_div_gen_if.sv | 26 ++
 rtl/clk_div_gen.sv | 89 ++++++++
 tb/tb_clk_div_gen.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/clk_div_gen_if.sv
// Configuration, run-control and output bundle of the multi-channel clock-enable generator.
// The divider drives Tick_Out/Sq_Out through the slave modport; its controller uses master.
interface clk_div_gen_if #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 24
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              Cfg_We;
   logic [CH_W-1:0]   Cfg_Ch;
   logic [CNT_W-1:0]  Cfg_Div;
   logic [NUM_CH-1:0] Ch_En;
   logic [NUM_CH-1:0] Step_Req;
   logic [NUM_CH-1:0] Tick_Out;
   logic [NUM_CH-1:0] Sq_Out;

   modport master (
      output Cfg_We, Cfg_Ch, Cfg_Div, Ch_En, Step_Req,
      input  Tick_Out, Sq_Out
   );

   modport slave (
      input  Cfg_We, Cfg_Ch, Cfg_Div, Ch_En, Step_Req,
      output Tick_Out, Sq_Out
   );
endinterface

// File: rtl/clk_div_gen.sv
// Multi-channel clock-enable generator: each channel divides Clk by a programmable ratio and
// emits a registered one-cycle tick plus a 50% square wave, with pause and single-step.
module clk_div_gen #(
   parameter int NUM_CH      = 2,
   parameter int CNT_W       = 24,
   parameter int DEFAULT_DIV = 16
) (
   input logic            Clk,
   input logic            Reset_n,
   clk_div_gen_if.slave   bus
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] div_act_q, div_act_d;
      logic [CNT_W-1:0] div_pend_q, div_pend_d;
      logic [CNT_W-1:0] last_cnt;
      logic             pend_vld_q, pend_vld_d;
      logic             step_prev_q, step_prev_d;
      logic             tick_q, tick_d;
      logic             sq_q, sq_d;
      logic             wrap, fire, wr_hit;

      // Divisors 0 and 1 both collapse to a single-cycle period.
      assign last_cnt = (div_act_q > CNT_W'(1)) ? (div_act_q - CNT_W'(1)) : '0;
      assign wrap     = (cnt_q == last_cnt);
      assign fire     = bus.Ch_En[i] ? wrap : (bus.Step_Req[i] & ~step_prev_q);
      assign wr_hit   = bus.Cfg_We && (32'(bus.Cfg_Ch) == i);

      always_comb begin
         cnt_d       = cnt_q;
         div_act_d   = div_act_q;
         div_pend_d  = div_pend_q;
         pend_vld_d  = pend_vld_q;
         step_prev_d = bus.Step_Req[i];
         tick_d      = 1'b0;
         sq_d        = sq_q;

         if (bus.Ch_En[i]) begin
            cnt_d = cnt_q + CNT_W'(1);
         end

         if (fire) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            sq_d   = ~sq_q;
            if (pend_vld_q) begin
               div_act_d  = div_pend_q;
               pend_vld_d = 1'b0;
            end
         end

         // A running channel only swaps divisors on a period boundary, so no period is cut short.
         if (wr_hit) begin
            if (!bus.Ch_En[i] || wrap) begin
               div_act_d  = bus.Cfg_Div;
               pend_vld_d = 1'b0;
            end else begin
               div_pend_d = bus.Cfg_Div;
               pend_vld_d = 1'b1;
            end
         end
      end

      always_ff @(posedge Clk or negedge Reset_n) begin
         if (!Reset_n) begin
            cnt_q       <= '0;
            div_act_q   <= CNT_W'(DEFAULT_DIV);
            div_pend_q  <= '0;
            pend_vld_q  <= 1'b0;
            step_prev_q <= 1'b0;
            tick_q      <= 1'b0;
            sq_q        <= 1'b0;
         end else begin
            cnt_q       <= cnt_d;
            div_act_q   <= div_act_d;
            div_pend_q  <= div_pend_d;
            pend_vld_q  <= pend_vld_d;
            step_prev_q <= step_prev_d;
            tick_q      <= tick_d;
            sq_q        <= sq_d;
         end
      end

      assign bus.Tick_Out[i] = tick_q;
      assign bus.Sq_Out[i]   = sq_q;
   end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed self-checking bench for clk_div_gen: three channels so that channel index 3 is a
// representable but out-of-range write target; r counts rising edges of the main scenario.
module tb_clk_div_gen;
   localparam int NUM_CH = 3;
   localparam int CNT_W  = 24;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   r      = 0;
   logic e_t0, e_t1, e_t2, e_s0, e_s1, e_s2, e_t, e_s;

   clk_div_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

   clk_div_gen #(
      .NUM_CH     (NUM_CH),
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(16)
   ) dut (
      .Clk    (clk),
      .Reset_n(rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s r=%0d observed=%0h expected=%0h", tag, r, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int ch, input int div);
      logic [31:0] ch_v;
      logic [31:0] div_v;
      ch_v        = ch;
      div_v       = div;
      bus.Cfg_We  = 1'b1;
      bus.Cfg_Ch  = ch_v[1:0];
      bus.Cfg_Div = div_v[CNT_W-1:0];
   endtask

   // Advance one rising edge and settle; a write strobe lasts exactly one edge.
   task automatic stepClock();
      @(posedge clk);
      #1;
      r++;
      bus.Cfg_We = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.Cfg_We   = 1'b0;
      bus.Cfg_Ch   = '0;
      bus.Cfg_Div  = '0;
      bus.Ch_En    = '0;
      bus.Step_Req = '0;
      #12;
      checkOutput("reset_tick", 32'(bus.Tick_Out), 32'd0);
      checkOutput("reset_sq", 32'(bus.Sq_Out), 32'd0);

      // Default divisor 16 on channels 0 and 1 from reset release.
      bus.Ch_En = 3'b011;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int e = 1; e <= 48; e++) begin
         stepClock();
         e_t = (e % 16 == 0);
         e_s = ((e / 16) % 2 == 1);
         checkOutput("default_tick", 32'(bus.Tick_Out), 32'({1'b0, e_t, e_t}));
         checkOutput("default_sq", 32'(bus.Sq_Out), 32'({1'b0, e_s, e_s}));
      end

      // Main scenario: divisor writes, out-of-range write, pause/step, third channel start.
      r = 0;
      for (int k = 1; k <= 150; k++) begin
         stepClock();
         e_t0 = ((((r >= 16) && (r <= 32)) || ((r >= 48) && (r <= 88))) && (r % 4 == 0))
                || (r == 99) || (r == 120) || (r == 136) || (r == 144);
         e_t1 = (r >= 64) || (r % 16 == 0);
         e_s1 = (r >= 64) ? (r % 2 == 0) : ((r / 16) % 2 == 0);
         e_t2 = (r == 137);
         e_s2 = (r >= 137);
         e_s0 = (r < 99) || ((r >= 120) && (r < 136)) || (r >= 144);
         checkOutput("tick", 32'(bus.Tick_Out), 32'({e_t2, e_t1, e_t0}));
         checkOutput("sq1", 32'(bus.Sq_Out[1]), 32'(e_s1));
         checkOutput("sq2", 32'(bus.Sq_Out[2]), 32'(e_s2));
         if ((r < 16) || (r >= 88)) begin
            checkOutput("sq0", 32'(bus.Sq_Out[0]), 32'(e_s0));
         end
         case (r)
            4:       applyStimulus(0, 4);
            28:      applyStimulus(0, 16);
            47:      applyStimulus(0, 4);
            56:      applyStimulus(1, 0);
            70:      applyStimulus(1, 1);
            76:      applyStimulus(3, 2);
            84:      applyStimulus(0, 16);
            95:      bus.Ch_En[0] = 1'b0;
            98:      bus.Step_Req[0] = 1'b1;
            101:     bus.Step_Req[0] = 1'b0;
            104:     bus.Ch_En[0] = 1'b1;
            108:     bus.Step_Req[0] = 1'b1;
            111:     bus.Step_Req[0] = 1'b0;
            121: begin
               bus.Ch_En[2] = 1'b1;
               applyStimulus(0, 8);
            end
            default: ;
         endcase
      end

      // Asynchronous reset mid-period with channel 0 at divisor 8.
      rst_n = 1'b0;
      #1;
      checkOutput("async_tick", 32'(bus.Tick_Out), 32'd0);
      checkOutput("async_sq", 32'(bus.Sq_Out), 32'd0);
      stepClock();
      stepClock();
      checkOutput("held_tick", 32'(bus.Tick_Out), 32'd0);
      checkOutput("held_sq", 32'(bus.Sq_Out), 32'd0);
      rst_n = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         stepClock();
         e_t = (k == 16);
         e_s = (k >= 16);
         checkOutput("post_reset_tick", 32'(bus.Tick_Out), 32'({e_t, e_t, e_t}));
         checkOutput("post_reset_sq", 32'(bus.Sq_Out), 32'({e_s, e_s, e_s}));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
